inst_fetch: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline. Sits directly upstream of the IF/ID register. It reads one 32-bit instruction per fetch as four sequential byte reads over the 8-bit memory port, assembles them, and presents `if_pc`/`if_inst` with a valid flag. Stall and branch redirect from the pipeline controller are honoured.

---
 rtl/inst_fetch_if.sv | 21 ++
 rtl/inst_fetch.sv | 119 +++++++++++
 tb/tb_inst_fetch.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Byte-wide instruction memory port between the fetch stage (master) and memory (slave).
interface inst_fetch_if;
  logic        mem_rd_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic [7:0]  mem_din_i;

  modport master (
    output mem_rd_o,
    output mem_addr_o,
    input  mem_gnt_i,
    input  mem_din_i
  );

  modport slave (
    input  mem_rd_o,
    input  mem_addr_o,
    output mem_gnt_i,
    output mem_din_i
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: four byte reads per instruction, big-endian assembly, stall hold
// and branch redirect with discard of in-flight bytes.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               branch_flag_i,
  input  logic [31:0]        branch_target_i,
  inst_fetch_if.master       mem,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_inst,
  output logic               if_valid
);

  typedef enum logic {S_FETCH, S_HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [2:0]  req_cnt, req_cnt_nxt;
  logic [2:0]  rcv_cnt, rcv_cnt_nxt;
  logic        pend, pend_nxt;
  logic [23:0] byte_buf, byte_buf_nxt;
  logic [31:0] if_pc_nxt, if_inst_nxt;
  logic        if_valid_nxt;

  logic        req_en;
  logic        gnt_ok;
  logic [31:0] req_addr;

  assign req_en   = (state == S_FETCH) && (req_cnt < 3'd4);
  assign req_addr = fetch_pc + {29'd0, req_cnt};
  assign gnt_ok   = req_en && mem.mem_gnt_i;

  // Gated by rst so the bus goes quiet the moment reset asserts, not at the next edge.
  assign mem.mem_rd_o   = rst && req_en;
  assign mem.mem_addr_o = (rst && req_en) ? req_addr : 32'd0;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_cnt_nxt  = req_cnt;
    rcv_cnt_nxt  = rcv_cnt;
    pend_nxt     = pend;
    byte_buf_nxt = byte_buf;
    if_pc_nxt    = if_pc;
    if_inst_nxt  = if_inst;
    if_valid_nxt = if_valid;

    if (branch_flag_i) begin
      // Clearing pend drops the byte returning next cycle; zeroed counters drop this cycle's grant.
      fetch_pc_nxt = branch_target_i;
      req_cnt_nxt  = 3'd0;
      rcv_cnt_nxt  = 3'd0;
      pend_nxt     = 1'b0;
      if_valid_nxt = 1'b0;
      state_nxt    = S_FETCH;
    end else begin
      case (state)
        S_FETCH: begin
          if (gnt_ok) req_cnt_nxt = req_cnt + 3'd1;
          pend_nxt = gnt_ok;
          if (pend) begin
            rcv_cnt_nxt = rcv_cnt + 3'd1;
            case (rcv_cnt)
              3'd0: byte_buf_nxt[23:16] = mem.mem_din_i;
              3'd1: byte_buf_nxt[15:8]  = mem.mem_din_i;
              3'd2: byte_buf_nxt[7:0]   = mem.mem_din_i;
              3'd3: begin
                if_inst_nxt  = {byte_buf, mem.mem_din_i};
                if_pc_nxt    = fetch_pc;
                if_valid_nxt = 1'b1;
                state_nxt    = S_HOLD;
              end
              default: ;
            endcase
          end
        end
        S_HOLD: begin
          pend_nxt = 1'b0;
          if (!stall_i) begin
            fetch_pc_nxt = fetch_pc + 32'd4;
            req_cnt_nxt  = 3'd0;
            rcv_cnt_nxt  = 3'd0;
            if_valid_nxt = 1'b0;
            state_nxt    = S_FETCH;
          end
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FETCH;
      fetch_pc <= RESET_PC;
      req_cnt  <= 3'd0;
      rcv_cnt  <= 3'd0;
      pend     <= 1'b0;
      byte_buf <= 24'd0;
      if_pc    <= 32'd0;
      if_inst  <= 32'd0;
      if_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_cnt  <= req_cnt_nxt;
      rcv_cnt  <= rcv_cnt_nxt;
      pend     <= pend_nxt;
      byte_buf <= byte_buf_nxt;
      if_pc    <= if_pc_nxt;
      if_inst  <= if_inst_nxt;
      if_valid <= if_valid_nxt;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a one-cycle-latency byte memory model.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        gnt;
  logic [7:0]  mem [0:1023];

  int checks = 0;
  int failures = 0;

  inst_fetch_if bus ();

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .mem             (bus),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .if_valid        (if_valid)
  );

  always #5 clk = ~clk;

  assign bus.mem_gnt_i = gnt;

  // Data returns one cycle after a grant; 0xEE otherwise so stray captures show up.
  always @(posedge clk) begin
    if (bus.mem_rd_o && bus.mem_gnt_i) bus.mem_din_i <= mem[bus.mem_addr_o[9:0]];
    else                               bus.mem_din_i <= 8'hEE;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[0] = 8'h13;  mem[1] = 8'h05;  mem[2] = 8'h10;  mem[3] = 8'h00;
    mem[4] = 8'hDE;  mem[5] = 8'hAD;  mem[6] = 8'hBE;  mem[7] = 8'hEF;
    mem[8] = 8'h11;  mem[9] = 8'h22;  mem[10] = 8'h33; mem[11] = 8'h44;
    mem[12] = 8'h55; mem[13] = 8'h66; mem[14] = 8'h77; mem[15] = 8'h88;
    mem[256] = 8'hA1; mem[257] = 8'hB2; mem[258] = 8'hC3; mem[259] = 8'hD4;
    mem[1022] = 8'h9A; mem[1023] = 8'hBC;

    rst = 1'b0; stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = 32'd0; gnt = 1'b1;
    #3;
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_inst", if_inst, 32'd0);
    chk("rst_rd", {31'd0, bus.mem_rd_o}, 32'd0);
    chk("rst_addr", bus.mem_addr_o, 32'd0);

    // release between edges: first request at RESET_PC immediately
    #19; rst = 1'b1; #1;
    chk("c0_rd", {31'd0, bus.mem_rd_o}, 32'd1);
    chk("c0_addr", bus.mem_addr_o, 32'd0);
    tick(); chk("c1_addr", bus.mem_addr_o, 32'd1);
    tick(); chk("c2_addr", bus.mem_addr_o, 32'd2);
    tick(); chk("c3_addr", bus.mem_addr_o, 32'd3);
    tick(); chk("c4_rd", {31'd0, bus.mem_rd_o}, 32'd0);
    chk("c4_valid", {31'd0, if_valid}, 32'd0);
    tick(); chk("c5_valid", {31'd0, if_valid}, 32'd1);
    chk("c5_pc", if_pc, 32'd0);
    chk("c5_inst", if_inst, 32'h1305_1000);

    // stall three cycles while valid
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_inst", if_inst, 32'h1305_1000);
      chk("stall_rd", {31'd0, bus.mem_rd_o}, 32'd0);
    end
    stall_i = 1'b0;
    tick(); chk("cons_addr", bus.mem_addr_o, 32'd4);
    chk("cons_valid", {31'd0, if_valid}, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("i2_notyet", {31'd0, if_valid}, 32'd0);
    tick(); chk("i2_valid", {31'd0, if_valid}, 32'd1);
    chk("i2_pc", if_pc, 32'd4);
    chk("i2_inst", if_inst, 32'hDEAD_BEEF);

    // grant withheld two cycles on byte 2
    tick(); chk("g_addr8", bus.mem_addr_o, 32'd8);
    tick(); chk("g_addr9", bus.mem_addr_o, 32'd9);
    tick(); chk("g_addr10a", bus.mem_addr_o, 32'd10);
    gnt = 1'b0;
    tick(); chk("g_addr10b", bus.mem_addr_o, 32'd10);
    tick(); chk("g_addr10c", bus.mem_addr_o, 32'd10);
    chk("g_rd_held", {31'd0, bus.mem_rd_o}, 32'd1);
    gnt = 1'b1;
    tick(); chk("g_addr11", bus.mem_addr_o, 32'd11);
    tick(); chk("g_notyet", {31'd0, if_valid}, 32'd0);
    tick(); chk("g_valid", {31'd0, if_valid}, 32'd1);
    chk("g_pc", if_pc, 32'd8);
    chk("g_inst", if_inst, 32'h1122_3344);

    // branch in the cycle after byte 1 is granted
    tick(); chk("b_addr12", bus.mem_addr_o, 32'd12);
    tick(); chk("b_addr13", bus.mem_addr_o, 32'd13);
    tick(); chk("b_addr14", bus.mem_addr_o, 32'd14);
    branch_flag_i = 1'b1; branch_target_i = 32'h100;
    tick(); branch_flag_i = 1'b0;
    chk("b_addr100", bus.mem_addr_o, 32'h100);
    chk("b_valid0", {31'd0, if_valid}, 32'd0);
    tick(); chk("b_addr101", bus.mem_addr_o, 32'h101);
    tick(); chk("b_addr102", bus.mem_addr_o, 32'h102);
    tick(); chk("b_addr103", bus.mem_addr_o, 32'h103);
    tick(); chk("b_notyet", {31'd0, if_valid}, 32'd0);
    tick(); chk("b_valid", {31'd0, if_valid}, 32'd1);
    chk("b_pc", if_pc, 32'h100);
    chk("b_inst", if_inst, 32'hA1B2_C3D4);

    // branch wins over simultaneous stall; stall does not block fetching
    stall_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'd4;
    tick(); branch_flag_i = 1'b0;
    chk("bs_valid0", {31'd0, if_valid}, 32'd0);
    chk("bs_addr4", bus.mem_addr_o, 32'd4);
    for (int i = 0; i < 4; i++) tick();
    tick(); chk("bs_valid", {31'd0, if_valid}, 32'd1);
    chk("bs_pc", if_pc, 32'd4);
    chk("bs_inst", if_inst, 32'hDEAD_BEEF);
    tick(); chk("bs_hold", {31'd0, if_valid}, 32'd1);

    // unaligned target with offset wrap past 0xFFFFFFFF
    stall_i = 1'b0; branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFFE;
    tick(); branch_flag_i = 1'b0;
    chk("w_addr_fe", bus.mem_addr_o, 32'hFFFF_FFFE);
    tick(); chk("w_addr_ff", bus.mem_addr_o, 32'hFFFF_FFFF);
    tick(); chk("w_addr_00", bus.mem_addr_o, 32'h0000_0000);
    tick(); tick(); tick();
    chk("w_pc", if_pc, 32'hFFFF_FFFE);
    chk("w_inst", if_inst, 32'h9ABC_1305);
    tick(); chk("w_next", bus.mem_addr_o, 32'h0000_0002);

    // asynchronous reset mid-fetch
    tick(); chk("r_addr3", bus.mem_addr_o, 32'd3);
    #2; rst = 1'b0; #1;
    chk("r_rd", {31'd0, bus.mem_rd_o}, 32'd0);
    chk("r_addr", bus.mem_addr_o, 32'd0);
    chk("r_valid", {31'd0, if_valid}, 32'd0);
    chk("r_pc", if_pc, 32'd0);
    chk("r_inst", if_inst, 32'd0);
    #2; rst = 1'b1; #1;
    chk("r_restart", {31'd0, bus.mem_rd_o}, 32'd1);
    chk("r_addr0", bus.mem_addr_o, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    tick(); chk("r_valid2", {31'd0, if_valid}, 32'd1);
    chk("r_inst2", if_inst, 32'h1305_1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
